// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the transmit-lane merge arbiter.
package tx_sched_pkg;

    localparam int LANES_MAX     = 8;
    localparam int STALL_MAX_DEF = 1024;

    typedef logic [2:0] lane_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last_grant+1 with wrap.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        w_idx     = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = IW'((int'(last_grant) + i) % N);
            if (!any && req[w_idx]) begin
                any       = 1'b1;
                grant_idx = w_idx;
            end
        end
        grant[grant_idx] = any;
    end

endmodule

// File: rtl/tx_lane_merge_arbiter.sv
// Frame-level round-robin merge of per-lane I/Q streams into one tagged I/Q stream,
// with frame counter and sticky stall / tlast-desync flags.
module tx_lane_merge_arbiter
    import tx_sched_pkg::*;
#(
    parameter int  LANES     = 8,
    parameter int  DW        = 16,
    parameter int  STALL_MAX = STALL_MAX_DEF,
    localparam int LW        = $clog2(LANES),
    localparam int SW        = $clog2(STALL_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LANES-1:0]    lane_en,
    input  logic                err_clr,
    input  logic [LANES-1:0]    s_i_tvalid,
    input  logic [LANES*DW-1:0] s_i_tdata,
    input  logic [LANES-1:0]    s_i_tlast,
    input  logic [LANES-1:0]    s_q_tvalid,
    input  logic [LANES*DW-1:0] s_q_tdata,
    input  logic [LANES-1:0]    s_q_tlast,
    output logic [LANES-1:0]    s_tready,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [DW-1:0]       m_i_tdata,
    output logic [DW-1:0]       m_q_tdata,
    output logic                m_tlast,
    output logic [LW-1:0]       m_tdest,
    output logic [31:0]         frame_cnt,
    output logic                stall_err,
    output logic                last_err,
    output arb_state_t          dbg_state
);

    arb_state_t       r_state;
    logic [LW-1:0]    r_grant;
    logic [LW-1:0]    r_last_grant;
    logic [LANES-1:0] r_grant_oh;
    logic             r_m_tvalid;
    logic             r_m_tlast;
    logic [DW-1:0]    r_m_i;
    logic [DW-1:0]    r_m_q;
    logic [LW-1:0]    r_m_tdest;
    logic [31:0]      r_frame_cnt;
    logic [SW-1:0]    r_stall_cnt;
    logic             r_stall_err;
    logic             r_last_err;

    logic [LANES-1:0] w_req;
    logic [LANES-1:0] w_pair_v;
    logic [LANES-1:0] w_gnt_oh;
    logic [LW-1:0]    w_gnt_idx;
    logic             w_any;
    logic             w_pair_g;
    logic             w_accept;
    logic             w_i_last;
    logic             w_q_last;
    logic             w_stall_set;
    logic             w_last_set;

    assign w_pair_v = s_i_tvalid & s_q_tvalid;
    assign w_req    = lane_en & w_pair_v;

    rr_arbiter #(.N(LANES), .IW(LW)) u_rr (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_gnt_oh),
        .grant_idx  (w_gnt_idx),
        .any        (w_any)
    );

    // Handshake: a beat moves on s_* when s_tready[g] is high, and on m_* when m_tvalid & m_tready;
    // the granted lane is ready only when both I and Q are valid and the output register can take a beat.
    assign w_pair_g    = w_pair_v[r_grant];
    assign w_accept    = reset && (r_state == GRANT) && w_pair_g && (!r_m_tvalid || m_tready);
    assign w_i_last    = s_i_tlast[r_grant];
    assign w_q_last    = s_q_tlast[r_grant];
    assign w_stall_set = reset && (r_state == GRANT) && !w_pair_g && (r_stall_cnt >= SW'(STALL_MAX - 1));
    assign w_last_set  = w_accept && (w_i_last != w_q_last);
    assign s_tready    = w_accept ? r_grant_oh : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= LW'(LANES - 1);
            r_grant_oh   <= '0;
            r_m_tvalid   <= 1'b0;
            r_m_tlast    <= 1'b0;
            r_m_i        <= '0;
            r_m_q        <= '0;
            r_m_tdest    <= '0;
            r_frame_cnt  <= '0;
            r_stall_cnt  <= '0;
            r_stall_err  <= 1'b0;
            r_last_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_i      <= s_i_tdata[int'(r_grant)*DW +: DW];
                r_m_q      <= s_q_tdata[int'(r_grant)*DW +: DW];
                r_m_tlast  <= w_i_last;
                r_m_tdest  <= r_grant;
            end else if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state      <= GRANT;
                        r_grant      <= w_gnt_idx;
                        r_last_grant <= w_gnt_idx;
                        r_grant_oh   <= w_gnt_oh;
                    end
                end
                GRANT: begin
                    // The I side's tlast alone decides where the frame ends.
                    if (w_accept && w_i_last) begin
                        r_state     <= IDLE;
                        r_frame_cnt <= r_frame_cnt + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (r_state != GRANT || w_accept) begin
                r_stall_cnt <= '0;
            end else if (!w_pair_g && r_stall_cnt != SW'(STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + SW'(1);
            end

            if (w_stall_set) begin
                r_stall_err <= 1'b1;
            end else if (err_clr) begin
                r_stall_err <= 1'b0;
            end

            if (w_last_set) begin
                r_last_err <= 1'b1;
            end else if (err_clr) begin
                r_last_err <= 1'b0;
            end
        end
    end

    assign m_tvalid  = r_m_tvalid;
    assign m_i_tdata = r_m_i;
    assign m_q_tdata = r_m_q;
    assign m_tlast   = r_m_tlast;
    assign m_tdest   = r_m_tdest;
    assign frame_cnt = r_frame_cnt;
    assign stall_err = r_stall_err;
    assign last_err  = r_last_err;
    assign dbg_state = r_state;

endmodule
